nibble_extend_ctrl: RTL and testbench
=====================================

NIBBLE_EXTEND_CTRL -- requirements
Module: nibble_extend_ctrl

Interface
REQ-001 Parameter IN_W, default 16, source width in bits; SHALL be a multiple of DIG_W.
REQ-002 Parameter OUT_W, default 32, result width in bits; SHALL be a multiple of DIG_W and >= IN_W.
REQ-003 Parameter DIG_W, default 4, digit width moved per transfer.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 data_in  input  DIG_W  source digit, LSB digit first.
REQ-007 in_valid  input  1  data_in valid.
REQ-008 in_ready  output  1  block accepts a digit.
REQ-009 mode  input  2  extension mode: 00 zero, 01 sign, 10 ones-fill, 11 reserved.
REQ-010 start  input  1  one-cycle request to extend the loaded value.
REQ-011 clear  input  1  abort and return to LOAD.
REQ-012 data_out  output  DIG_W  result digit, LSB digit first.
REQ-013 out_valid  output  1  data_out valid.
REQ-014 out_ready  input  1  consumer accepts data_out.
REQ-015 busy  output  1  high in any state other than LOAD.

Function
REQ-016 FSM states SHALL be LOAD, FULL, EXTEND and DRAIN.
REQ-017 LOAD: in_ready=1; each cycle with in_valid=1 SHALL write data_in to source digit wr_idx, then increment wr_idx.
REQ-018 Accepting digit IN_W/DIG_W-1 SHALL move to FULL, deassert in_ready in the next cycle, and wrap wr_idx to 0.
REQ-019 FULL: start=1 SHALL sample mode and move to EXTEND; in_valid SHALL be ignored.
REQ-020 start outside FULL SHALL be ignored.
REQ-021 EXTEND (one cycle): result[IN_W-1:0]=source; upper OUT_W-IN_W bits = 0 (mode 00), source[IN_W-1] (01), all ones (10), 0 (11). Then SHALL move to DRAIN.
REQ-022 DRAIN: out_valid=1, data_out=result digit rd_idx; on out_valid&out_ready, rd_idx SHALL increment.
REQ-023 Transfer of digit OUT_W/DIG_W-1 SHALL wrap rd_idx to 0 and return to LOAD, with in_ready=1 in the next cycle.
REQ-024 data_out and out_valid SHALL hold stable while out_ready=0.
REQ-025 clear=1 in any state SHALL return to LOAD next cycle and zero wr_idx, rd_idx, out_valid; source and result contents need not be cleared.
REQ-026 clear SHALL take priority over start, in_valid and out_ready in the same cycle.
REQ-027 Latency: start accepted in cycle N -> first out_valid in cycle N+2.
REQ-028 Outside DRAIN, data_out SHALL be 0.

Reset
REQ-029 rst_n=0 at a rising edge SHALL force LOAD, wr_idx=0, rd_idx=0, source=0, result=0, in_ready=1 after the edge, out_valid=0, data_out=0, busy=0.
REQ-030 Reset mid-load or mid-drain SHALL discard all partial data; no digit output follows reset until a new full load and start.

Configuration
REQ-031 Macro NIBBLE_EXTEND_ONES_FILL_EN defined: mode 10 SHALL perform ones-fill as in REQ-021.
REQ-032 Macro undefined: mode 10 SHALL behave as mode 00 (zero-extend); all other behaviour unchanged.

Verification
REQ-033 Load 1,0,0,8 (0x8001), mode 01, start, out_ready=1 -> out digits 1,0,0,8,F,F,F,F (0xFFFF8001), then in_ready=1.
REQ-034 Load 0x8001, mode 00 -> 0x00008001; load 0x7FFF, mode 01 -> 0x00007FFF.
REQ-035 Load 0x1234, mode 10 -> 0xFFFF1234 with macro, 0x00001234 without.
REQ-036 Drain with out_ready toggling 1,0,0,1,... -> data_out held during stalls; exactly 8 transfers; start at cycle N -> out_valid at N+2.
REQ-037 clear asserted with start in FULL -> LOAD, no out_valid; rst_n=0 after 3 drained digits -> out_valid=0, in_ready=1, busy=0.
REQ-038 IN_W=8, OUT_W=24: load 0x80, mode 01 -> 0xFFFF80.

Source files
------------

// File: rtl/nibble_extend_ctrl.sv
// ---------------------------------------------------------------------------
// nibble_extend_ctrl
//
// Purpose:
//   Collects an IN_W-bit source value one DIG_W-bit digit at a time, least
//   significant digit first. On a start request it extends the value to OUT_W
//   bits using the selected extension mode. It then streams the result back
//   out one digit at a time, again least significant digit first, under
//   valid/ready flow control.
//
// Parameters:
//   IN_W   source width in bits (multiple of DIG_W)
//   OUT_W  result width in bits (multiple of DIG_W, >= IN_W)
//   DIG_W  digit width moved per transfer
//
// Ports:
//   clk        single clock, rising edge
//   rst_n      synchronous active-low reset
//   data_in    source digit
//   in_valid   data_in is valid
//   in_ready   block accepts a digit (LOAD state)
//   mode       extension mode: 00 zero, 01 sign, 10 ones-fill, 11 reserved (zero)
//   start      one-cycle request to extend the loaded value (honoured in FULL only)
//   clear      abort and return to LOAD; has priority over everything else
//   data_out   result digit, zero outside DRAIN
//   out_valid  data_out is valid (DRAIN state)
//   out_ready  consumer accepts data_out
//   busy       high in any state other than LOAD
//
// Configuration:
//   NIBBLE_EXTEND_ONES_FILL_EN  when defined, mode 10 fills the upper bits with
//                               ones; otherwise mode 10 zero-extends.
// ---------------------------------------------------------------------------
module nibble_extend_ctrl #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int DIG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIG_W-1:0] data_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic             start,
  input  logic             clear,
  output logic [DIG_W-1:0] data_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int IN_DIGS  = IN_W / DIG_W;
  localparam int OUT_DIGS = OUT_W / DIG_W;
  localparam int WR_W     = (IN_DIGS  > 1) ? $clog2(IN_DIGS)  : 1;
  localparam int RD_W     = (OUT_DIGS > 1) ? $clog2(OUT_DIGS) : 1;

  localparam logic [WR_W-1:0]  WR_LAST    = WR_W'(IN_DIGS - 1);
  localparam logic [RD_W-1:0]  RD_LAST    = RD_W'(OUT_DIGS - 1);
  // Selects only the bits above the copied source field.
  localparam logic [OUT_W-1:0] UPPER_MASK = {OUT_W{1'b1}} << IN_W;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_FULL,
    ST_EXTEND,
    ST_DRAIN
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [WR_W-1:0]   wr_idx_q;
  logic [RD_W-1:0]   rd_idx_q;
  logic [IN_W-1:0]   source_q;
  logic [OUT_W-1:0]  result_q;
  logic [1:0]        mode_q;
  logic [OUT_W-1:0]  fill_word;
  logic [OUT_W-1:0]  extended;
  logic [DIG_W-1:0]  rd_digit;
  logic              wr_last;
  logic              rd_last;
  logic              accept_in;
  logic              xfer_out;

  assign wr_last   = (wr_idx_q == WR_LAST);
  assign rd_last   = (rd_idx_q == RD_LAST);
  assign accept_in = (state_q == ST_LOAD) && in_valid;
  assign xfer_out  = (state_q == ST_DRAIN) && out_ready;

  // State register: the only place the FSM state is stored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. clear overrides every other transition, so an abort in
  // the same cycle as start or a final transfer always lands in LOAD.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_LOAD;
    end else begin
      case (state_q)
        ST_LOAD:   if (in_valid && wr_last)  state_d = ST_FULL;
        ST_FULL:   if (start)                state_d = ST_EXTEND;
        ST_EXTEND:                           state_d = ST_DRAIN;
        ST_DRAIN:  if (out_ready && rd_last) state_d = ST_LOAD;
        default:                             state_d = ST_LOAD;
      endcase
    end
  end

  // Output decode. All handshake outputs are a pure function of the state,
  // so data_out/out_valid hold steady while the consumer stalls.
  always_comb begin
    in_ready  = (state_q == ST_LOAD);
    out_valid = (state_q == ST_DRAIN);
    busy      = (state_q != ST_LOAD);
    data_out  = (state_q == ST_DRAIN) ? rd_digit : '0;
  end

  // Read-side digit selection from the extended result.
  always_comb begin
    rd_digit = '0;
    for (int i = 0; i < OUT_DIGS; i++) begin
      if (rd_idx_q == RD_W'(i)) rd_digit = result_q[i*DIG_W +: DIG_W];
    end
  end

  // Extension value for the upper result bits. Mode 11 is reserved and
  // zero-extends. Mode 10 also zero-extends unless ones-fill is built in.
  always_comb begin
    case (mode_q)
      2'b01:   fill_word = {OUT_W{source_q[IN_W-1]}};
`ifdef NIBBLE_EXTEND_ONES_FILL_EN
      2'b10:   fill_word = {OUT_W{1'b1}};
`endif
      default: fill_word = '0;
    endcase
    extended = (fill_word & UPPER_MASK) | OUT_W'(source_q);
  end

  // Datapath registers: source capture, mode sample, result build and
  // read index. clear only rewinds the indices; stale source/result
  // contents are harmless because they are always rewritten before use.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      source_q <= '0;
      result_q <= '0;
      mode_q   <= '0;
    end else if (clear) begin
      wr_idx_q <= '0;
      rd_idx_q <= '0;
    end else begin
      if (accept_in) begin
        for (int i = 0; i < IN_DIGS; i++) begin
          if (wr_idx_q == WR_W'(i)) source_q[i*DIG_W +: DIG_W] <= data_in;
        end
        wr_idx_q <= wr_last ? '0 : wr_idx_q + WR_W'(1);
      end
      if ((state_q == ST_FULL) && start) begin
        mode_q <= mode;
      end
      if (state_q == ST_EXTEND) begin
        result_q <= extended;
      end
      if (xfer_out) begin
        rd_idx_q <= rd_last ? '0 : rd_idx_q + RD_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_nibble_extend_ctrl.sv
// ---------------------------------------------------------------------------
// tb_nibble_extend_ctrl
//
// Purpose:
//   Self-checking bench for nibble_extend_ctrl. A wide instance (16 -> 32) and
//   a narrow instance (8 -> 24) share the clock and reset. Expected results
//   come from an arithmetic extension model, not from the design.
// ---------------------------------------------------------------------------
module tb_nibble_extend_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic [3:0] data_in = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] mode = '0;
  logic       start = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] data_out;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       busy;

  logic [3:0] n_data_in = '0;
  logic       n_in_valid = 1'b0;
  logic       n_in_ready;
  logic [1:0] n_mode = '0;
  logic       n_start = 1'b0;
  logic       n_clear = 1'b0;
  logic [3:0] n_data_out;
  logic       n_out_valid;
  logic       n_out_ready = 1'b0;
  logic       n_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nibble_extend_ctrl #(.IN_W(16), .OUT_W(32), .DIG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .start(start), .clear(clear),
    .data_out(data_out), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy)
  );

  nibble_extend_ctrl #(.IN_W(8), .OUT_W(24), .DIG_W(4)) dut_narrow (
    .clk(clk), .rst_n(rst_n), .data_in(n_data_in), .in_valid(n_in_valid),
    .in_ready(n_in_ready), .mode(n_mode), .start(n_start), .clear(n_clear),
    .data_out(n_data_out), .out_valid(n_out_valid), .out_ready(n_out_ready),
    .busy(n_busy)
  );

  // Reference: extend a 16-bit value to 32 bits as a number.
  function automatic logic [31:0] model_wide(input logic [15:0] src, input logic [1:0] m);
    logic signed [31:0] s;
    s = $signed(src);
    case (m)
      2'b01: return s;
`ifdef NIBBLE_EXTEND_ONES_FILL_EN
      2'b10: return 32'hFFFF_0000 | 32'(src);
`endif
      default: return 32'(src);
    endcase
  endfunction

  function automatic logic [23:0] model_narrow(input logic [7:0] src, input logic [1:0] m);
    logic signed [23:0] s;
    s = $signed(src);
    case (m)
      2'b01: return s;
`ifdef NIBBLE_EXTEND_ONES_FILL_EN
      2'b10: return 24'hFFFF00 | 24'(src);
`endif
      default: return 24'(src);
    endcase
  endfunction

  // Feeds four digits LSB first, optionally with idle gaps; ends on a negedge
  // with the block expected to sit in FULL.
  task automatic load_value(input logic [15:0] v, input bit gaps);
    for (int d = 0; d < 4; d++) begin
      bit sent = 1'b0;
      int guard = 0;
      while (!sent) begin
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("[TB] FAIL load_in_ready digit %0d got %b exp 1", d, in_ready);
        end
        in_valid = (gaps && guard < 8) ? ($urandom_range(0, 2) != 0) : 1'b1;
        data_in  = v[d*4 +: 4];
        sent     = in_valid;
        guard++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL full_state in_ready=%b busy=%b exp 0/1", in_ready, busy);
    end
  endtask

  // Issues start from FULL and drains eight digits. stall: 0 always ready,
  // 1 ready pattern 1,0,0, 2 random ready.
  task automatic run_extend(input logic [1:0] m, input int stall, output logic [31:0] got);
    int n = 0;
    int cyc = 0;
    logic prev_stall = 1'b0;
    logic [3:0] prev_data = '0;
    got   = '0;
    start = 1'b1;
    mode  = m;
    @(negedge clk);
    start = 1'b0;
    mode  = 2'($urandom_range(0, 3));
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL extend_cycle out_valid=%b busy=%b exp 0/1", out_valid, busy);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL latency out_valid got %b exp 1 two cycles after start", out_valid);
    end
    while (n < 8 && cyc < 200) begin
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL drain_valid after %0d transfers got %b exp 1", n, out_valid);
      end
      if (prev_stall) begin
        checks++;
        if (data_out !== prev_data) begin
          errors++;
          $display("[TB] FAIL stall_hold data_out got %h exp %h", data_out, prev_data);
        end
      end
      case (stall)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (out_valid && out_ready) begin
        got[n*4 +: 4] = data_out;
        n++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = data_out;
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    checks++;
    if (n != 8) begin
      errors++;
      $display("[TB] FAIL drain_timeout transfers got %0d exp 8", n);
    end
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || data_out !== 4'h0) begin
      errors++;
      $display("[TB] FAIL after_drain in_ready=%b busy=%b out_valid=%b data_out=%h exp 1/0/0/0",
               in_ready, busy, out_valid, data_out);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || data_out !== 4'h0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state in_ready=%b out_valid=%b data_out=%h busy=%b exp 1/0/0/0",
               in_ready, out_valid, data_out, busy);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [15:0] vals [6] = '{16'h8001, 16'h8001, 16'h7FFF, 16'h1234, 16'h1234, 16'hFFFF};
    logic [1:0]  mds  [6] = '{2'b01, 2'b00, 2'b01, 2'b10, 2'b11, 2'b01};
    logic [31:0] got;
    logic [31:0] exp;
    for (int i = 0; i < 6; i++) begin
      load_value(vals[i], 1'b0);
      run_extend(mds[i], 0, got);
      exp = model_wide(vals[i], mds[i]);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("[TB] FAIL directed_%0d src=%h mode=%b got %h exp %h", i, vals[i], mds[i], got, exp);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] got;
    load_value(16'h8001, 1'b0);
    run_extend(2'b01, 1, got);
    checks++;
    if (got !== model_wide(16'h8001, 2'b01)) begin
      errors++;
      $display("[TB] FAIL stall_result got %h exp %h", got, model_wide(16'h8001, 2'b01));
    end
  endtask

  task automatic test_random();
    logic [31:0] got;
    logic [15:0] v;
    logic [1:0]  m;
    for (int i = 0; i < 12; i++) begin
      v = 16'($urandom);
      m = 2'($urandom_range(0, 3));
      load_value(v, 1'b1);
      run_extend(m, 2, got);
      checks++;
      if (got !== model_wide(v, m)) begin
        errors++;
        $display("[TB] FAIL random_%0d src=%h mode=%b got %h exp %h", i, v, m, got, model_wide(v, m));
      end
    end
  endtask

  task automatic test_ignored();
    logic [31:0] got;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL start_in_load busy=%b in_ready=%b exp 0/1", busy, in_ready);
    end
    load_value(16'hA5C3, 1'b0);
    in_valid = 1'b1;
    data_in  = 4'hF;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL in_valid_in_full in_ready=%b busy=%b exp 0/1", in_ready, busy);
    end
    run_extend(2'b01, 0, got);
    checks++;
    if (got !== model_wide(16'hA5C3, 2'b01)) begin
      errors++;
      $display("[TB] FAIL full_ignore_data got %h exp %h", got, model_wide(16'hA5C3, 2'b01));
    end
  endtask

  task automatic test_clear();
    logic [31:0] got;
    bit seen;
    // clear together with start in FULL
    load_value(16'h4321, 1'b0);
    clear = 1'b1;
    start = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL clear_start busy=%b in_ready=%b exp 0/1", busy, in_ready);
    end
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("[TB] FAIL clear_no_output out_valid seen 1 exp 0");
    end
    // clear mid-load with in_valid high, then a fresh load must start at digit 0
    @(negedge clk);
    in_valid = 1'b1;
    data_in  = 4'hA;
    @(negedge clk);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    load_value(16'h0F1E, 1'b0);
    run_extend(2'b00, 0, got);
    checks++;
    if (got !== model_wide(16'h0F1E, 2'b00)) begin
      errors++;
      $display("[TB] FAIL clear_mid_load got %h exp %h", got, model_wide(16'h0F1E, 2'b00));
    end
    // clear mid-drain, then a fresh drain must start at digit 0
    load_value(16'h9876, 1'b0);
    start = 1'b1;
    mode  = 2'b01;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear     = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || data_out !== 4'h0) begin
      errors++;
      $display("[TB] FAIL clear_mid_drain out_valid=%b busy=%b data_out=%h exp 0/0/0",
               out_valid, busy, data_out);
    end
    load_value(16'h5A5A, 1'b0);
    run_extend(2'b01, 0, got);
    checks++;
    if (got !== model_wide(16'h5A5A, 2'b01)) begin
      errors++;
      $display("[TB] FAIL clear_rd_rewind got %h exp %h", got, model_wide(16'h5A5A, 2'b01));
    end
  endtask

  task automatic test_reset_mid_drain();
    bit seen;
    load_value(16'h8001, 1'b0);
    start = 1'b1;
    mode  = 2'b01;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    out_ready = 1'b0;
    rst_n     = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_drain out_valid=%b in_ready=%b busy=%b exp 0/1/0",
               out_valid, in_ready, busy);
    end
    start     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen  = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    out_ready = 1'b0;
    checks++;
    if (seen) begin
      errors++;
      $display("[TB] FAIL reset_no_output out_valid seen 1 exp 0");
    end
  endtask

  task automatic test_narrow();
    logic [7:0]  vals [3] = '{8'h80, 8'h3C, 8'hC7};
    logic [1:0]  mds  [3] = '{2'b01, 2'b01, 2'b10};
    logic [23:0] got;
    int n;
    int cyc;
    for (int i = 0; i < 3; i++) begin
      for (int d = 0; d < 2; d++) begin
        @(negedge clk);
        n_in_valid = 1'b1;
        n_data_in  = vals[i][d*4 +: 4];
      end
      @(negedge clk);
      n_in_valid = 1'b0;
      n_start    = 1'b1;
      n_mode     = mds[i];
      @(negedge clk);
      n_start = 1'b0;
      @(negedge clk);
      got = '0;
      n   = 0;
      cyc = 0;
      n_out_ready = 1'b1;
      while (n < 6 && cyc < 50) begin
        if (n_out_valid) begin
          got[n*4 +: 4] = n_data_out;
          n++;
        end
        @(negedge clk);
        cyc++;
      end
      n_out_ready = 1'b0;
      checks++;
      if (got !== model_narrow(vals[i], mds[i]) || n_in_ready !== 1'b1) begin
        errors++;
        $display("[TB] FAIL narrow_%0d src=%h mode=%b got %h exp %h in_ready=%b",
                 i, vals[i], mds[i], got, model_narrow(vals[i], mds[i]), n_in_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_random();
    test_ignored();
    test_clear();
    test_reset_mid_drain();
    test_narrow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
